weight_fetch_ctrl: RTL

- Read-side master for the signed weight ROM. The ROM has one-cycle registered read latency, an address input, a read-enable input and a DW+1-bit data output.
- On a start pulse it walks a contiguous weight window, which wraps modulo ROM_SIZE. It issues ROM reads, captures the returned words and streams them to the systolic-array weight loader over a valid/ready interface.
- A small internal FIFO absorbs the ROM latency so backpressure never loses data.

---
 rtl/lenet_sa_pkg.sv | 21 ++
 rtl/wf_sync_fifo.sv | 63 ++++++
 rtl/weight_fetch_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lenet_sa_pkg.sv
// Shared types and sizing helpers for the LeNet systolic-array weight path.
package lenet_sa_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } wf_state_e;

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return int'($clog2(depth + 1));
  endfunction

endpackage

// File: rtl/wf_sync_fifo.sv
// Synchronous FIFO with occupancy count; the head is read from registered storage
// and forced to zero while empty.
module wf_sync_fifo
  import lenet_sa_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  localparam int unsigned       PtrW    = ptr_width(DEPTH);
  localparam logic [PtrW-1:0]   PtrLast = PtrW'(DEPTH - 1);
  localparam logic [PtrW-1:0]   PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0]   CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0]   CntOne  = CntW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_pop  = rd_en && (count_q != '0);
  // A push into a full FIFO is accepted only when a pop frees the slot the same cycle.
  assign do_push = wr_en && ((count_q != CntFull) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight ROM read master: walks a wrapping address window, absorbs the one-cycle ROM
// latency in a credit-controlled FIFO and streams words to the loader over valid/ready.
module weight_fetch_ctrl
  import lenet_sa_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned ADDR_DW    = 5,
  parameter int unsigned ROM_SIZE   = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_DW-1:0]   base_addr,
  input  logic [ADDR_DW:0]     len,
  output logic [ADDR_DW-1:0]   rom_addr,
  output logic                 rom_ra_enable,
  input  logic signed [DW:0]   rom_dout,
  output logic signed [DW:0]   w_data,
  output logic                 w_valid,
  output logic                 w_last,
  input  logic                 w_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned        CntW     = cnt_width(FIFO_DEPTH);
  localparam logic [ADDR_DW-1:0] LastAddr = ADDR_DW'(ROM_SIZE - 1);
  localparam logic [ADDR_DW-1:0] AddrOne  = ADDR_DW'(1);
  localparam logic [ADDR_DW:0]   LenOne   = (ADDR_DW + 1)'(1);

  wf_state_e            state_q, state_d;
  logic [ADDR_DW-1:0]   cur_q, cur_d;
  logic [ADDR_DW:0]     len_q, len_d;
  logic [ADDR_DW:0]     issued_q, issued_d;
  logic [ADDR_DW:0]     captured_q, captured_d;
  logic                 inflight_q;
  logic                 has_credit, issue, pop, push_last;
  logic [CntW-1:0]      fifo_count;
  logic                 fifo_empty;
  logic [DW+1:0]        fifo_head;

  // Reads in flight count against FIFO space so a capture never finds it full.
  assign has_credit = (32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH;
  assign issue      = (state_q == StFetch) && (issued_q < len_q) && has_credit;
  assign push_last  = ((captured_q + LenOne) == len_q);
  assign pop        = w_valid && w_ready;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    len_d      = len_q;
    issued_d   = issued_q;
    captured_d = inflight_q ? captured_q + LenOne : captured_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_d      = base_addr;
          len_d      = len;
          issued_d   = '0;
          captured_d = '0;
          state_d    = (len == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (issue) begin
          cur_d    = (cur_q == LastAddr) ? '0 : cur_q + AddrOne;
          issued_d = issued_q + LenOne;
          if ((issued_q + LenOne) == len_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && fifo_head[DW+1]) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      captured_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      captured_q <= captured_d;
      inflight_q <= issue;
    end
  end

  wf_sync_fifo #(
    .WIDTH (DW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (inflight_q),
    .wr_data ({push_last, rom_dout}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rom_ra_enable = issue;
  assign rom_addr      = issue ? cur_q : '0;
  assign w_valid       = !fifo_empty;
  assign w_data        = fifo_head[DW:0];
  assign w_last        = fifo_head[DW+1];
  assign busy          = (state_q == StFetch) || (state_q == StDrain);
  assign done          = (state_q == StDone);

endmodule
